// File: rtl/debug_pkg.sv
// Purpose: shared opcodes, notify byte, FSM encoding and command layout for the debug step controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package debug_pkg;

    localparam logic [5:0] OP_STEP   = 6'h20;
    localparam logic [5:0] OP_RUN    = 6'h23;
    localparam logic [5:0] OP_HALT   = 6'h24;
    localparam logic [5:0] OP_CYCLES = 6'h25;

    // Sent once when the pipeline stops itself (halt instruction / breakpoint).
    localparam logic [7:0] NOTIFY_BYTE = 8'hB0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_RUN,
        ST_LATCH,
        ST_SEND,
        ST_NOTIFY
    } state_t;

    // Command byte as received from the UART: size in the top two bits.
    typedef struct packed {
        logic [1:0] size;
        logic [5:0] code;
    } cmd_t;

    // Size field encodes (bytes - 1).
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        return {1'b0, size} + 3'd1;
    endfunction

endpackage

// File: rtl/debug_tx_shifter.sv
// Purpose: byte-serial shift-out of a 32-bit word, LSB first, 1-4 bytes.
// Latency: first byte valid the cycle after load; one byte per accepted transfer.
// Backpressure: tx_data/tx_valid held stable while tx_ready is low.
//
// Ports: clock/reset (async active-low); load_vld/load_dat/load_cnt start a
// burst; tx_data/tx_valid/tx_ready to the UART transmitter; done pulses
// combinationally in the cycle the last byte transfers.
module debug_tx_shifter (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_vld,
    input  logic [31:0] load_dat,
    input  logic [2:0]  load_cnt,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    logic [31:0] shift_q;
    logic [2:0]  cnt_q;
    logic        vld_q;

    assign tx_data  = shift_q[7:0];
    assign tx_valid = vld_q;
    assign done     = vld_q & tx_ready & (cnt_q == 3'd1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q <= 32'h0;
            cnt_q   <= 3'd0;
            vld_q   <= 1'b0;
        end else if (load_vld) begin
            shift_q <= load_dat;
            cnt_q   <= load_cnt;
            vld_q   <= (load_cnt != 3'd0);
        end else if (vld_q && tx_ready) begin
            if (cnt_q == 3'd1) begin
                // Clear the data lane once the burst ends so tx_data idles at 0.
                shift_q <= 32'h0;
                cnt_q   <= 3'd0;
                vld_q   <= 1'b0;
            end else begin
                shift_q <= {8'h00, shift_q[31:8]};
                cnt_q   <= cnt_q - 3'd1;
            end
        end
    end

endmodule

// File: rtl/debug_step_controller.sv
// Purpose: debugger sequencer - step/run/halt pipeline clock enable, probe capture and byte readback.
// Latency: step/run enable 1 cycle after command; probe bytes start 2 cycles after command.
// Backpressure: cmd_ready low outside IDLE/RUN; response bytes wait on tx_ready.
//
// Ports: clock, reset (async active-low); cmd_data/cmd_valid/cmd_ready from the
// UART receiver; tx_data/tx_valid/tx_ready to the UART transmitter; pipe_en to
// the pipeline stage registers; probe_sel/probe_data to/from the probe mux;
// halt_req from the pipeline; running is high while free-running.
// PROBE_W must stay 32.
// Optional build macro DEBUG_CYCLE_COUNTER_EN adds a pipeline cycle counter read
// by opcode CYCLES; without it CYCLES is an ordinary probe read.
module debug_step_controller
    import debug_pkg::*;
#(
    parameter int PROBE_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         cmd_data,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               pipe_en,
    output logic [5:0]         probe_sel,
    input  logic [PROBE_W-1:0] probe_data,
    input  logic               halt_req,
    output logic               running
);

    state_t      state;
    cmd_t        cmd;
    logic [1:0]  size_q;
    logic        cmd_xfer;
    logic        load_vld;
    logic [31:0] load_dat;
    logic [2:0]  load_cnt;
    logic        tx_done;

    assign cmd = cmd_t'(cmd_data);

    // Gated by reset so the upstream sees no acceptance while held in reset.
    assign cmd_ready = reset & ((state == ST_IDLE) | (state == ST_RUN));
    assign cmd_xfer  = cmd_valid & cmd_ready;

`ifdef DEBUG_CYCLE_COUNTER_EN
    logic [31:0] cycle_q;

    // Counts enabled pipeline cycles; wraps naturally, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_q <= 32'h0;
        end else if (pipe_en) begin
            cycle_q <= cycle_q + 32'd1;
        end
    end
`endif

    // The shifter serves both probe readback and the single notify byte.
    always_comb begin
        load_vld = 1'b0;
        load_dat = probe_data;
        load_cnt = byte_count(size_q);
        if (state == ST_LATCH) begin
            load_vld = 1'b1;
`ifdef DEBUG_CYCLE_COUNTER_EN
            if (probe_sel == OP_CYCLES) begin
                load_dat = cycle_q;
            end
`endif
        end else if ((state == ST_RUN) && halt_req) begin
            load_vld = 1'b1;
            load_dat = {24'h0, NOTIFY_BYTE};
            load_cnt = 3'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            pipe_en   <= 1'b0;
            running   <= 1'b0;
            probe_sel <= 6'h00;
            size_q    <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_xfer) begin
                        case (cmd.code)
                            OP_STEP: begin
                                state   <= ST_STEP;
                                pipe_en <= 1'b1;
                            end
                            OP_RUN: begin
                                state   <= ST_RUN;
                                pipe_en <= 1'b1;
                                running <= 1'b1;
                            end
                            OP_HALT: begin
                                state <= ST_IDLE;
                            end
                            default: begin
                                probe_sel <= cmd.code;
                                size_q    <= cmd.size;
                                state     <= ST_LATCH;
                            end
                        endcase
                    end
                end
                ST_STEP: begin
                    pipe_en <= 1'b0;
                    state   <= ST_IDLE;
                end
                ST_RUN: begin
                    // A pipeline-initiated stop outranks a simultaneous HALT
                    // so the debugger always learns about the breakpoint.
                    if (halt_req) begin
                        pipe_en <= 1'b0;
                        running <= 1'b0;
                        state   <= ST_NOTIFY;
                    end else if (cmd_xfer && (cmd.code == OP_HALT)) begin
                        pipe_en <= 1'b0;
                        running <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_LATCH: begin
                    state <= ST_SEND;
                end
                ST_SEND, ST_NOTIFY: begin
                    if (tx_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    pipe_en <= 1'b0;
                    running <= 1'b0;
                end
            endcase
        end
    end

    debug_tx_shifter u_tx_shifter (
        .clock    (clock),
        .reset    (reset),
        .load_vld (load_vld),
        .load_dat (load_dat),
        .load_cnt (load_cnt),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (tx_done)
    );

endmodule

// File: tb/tb_debug_step_controller.sv
// Purpose: self-checking bench for debug_step_controller with a behavioural model.
// Latency: n/a.
// Backpressure: exercised by stalling tx_ready during responses.
module tb_debug_step_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        pipe_en;
    logic [5:0]  probe_sel;
    logic [31:0] probe_data;
    logic        halt_req;
    logic        running;

    int n_tests = 0;
    int n_fail  = 0;

    // Probe mux model: one value per select code; code 6'h25 reads 0.
    logic [31:0] probe_mem [64];
    assign probe_data = probe_mem[probe_sel];

    // Model of the enabled-cycle counter, derived from the commands issued.
    logic [31:0] cnt_model = 32'h0;

    always #5 clock = ~clock;

    debug_step_controller #(.PROBE_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .pipe_en    (pipe_en),
        .probe_sel  (probe_sel),
        .probe_data (probe_data),
        .halt_req   (halt_req),
        .running    (running)
    );

    // Cycle index: constant between rising edges.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int pe_cnt = 0, pe_first = -1, pe_last = -1, tv_cnt = 0;
    always @(negedge clock) begin
        if (pipe_en === 1'b1) begin
            pe_cnt++;
            if (pe_first < 0) pe_first = cyc;
            pe_last = cyc;
        end
        if (tx_valid === 1'b1) tv_cnt++;
    end

    task automatic clear_mon();
        pe_cnt = 0; pe_first = -1; pe_last = -1; tv_cnt = 0;
    endtask

    // Returns the cycle index in which the byte was accepted.
    task automatic send_cmd(input logic [7:0] b, output int t_acc);
        int got;
        got = 0; t_acc = -1;
        @(posedge clock); #1;
        cmd_data = b; cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (cmd_ready === 1'b1) begin got = 1; t_acc = cyc; break; end
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0; cmd_data = 8'($urandom);
        if (got == 0) begin
            n_tests++; n_fail++;
            $display("FAIL send_cmd_%02h: cmd_ready got 0 want 1 within 50 cycles", b);
        end
    endtask

    // Probe read; stalls tx_ready for stall_len cycles when byte stall_idx is presented.
    task automatic do_read(input logic [7:0] b, input logic [31:0] val,
                           input int stall_idx, input int stall_len);
        int t, nb, stalled;
        logic [7:0] got_q[$];
        logic [7:0] exp_b, act_b;
        nb = int'(b[7:6]) + 1;
        stalled = 0;
        tx_ready = 1'b1;
        send_cmd(b, t);
        @(negedge clock);
        n_tests++;
        if (tx_valid !== 1'b0 || probe_sel !== b[5:0]) begin
            n_fail++;
            $display("FAIL read_latch_%02h: tx_valid=%b probe_sel=%h want 0 and %h", b, tx_valid, probe_sel, b[5:0]);
        end
        for (int i = 0; i < 60 && got_q.size() < nb; i++) begin
            @(posedge clock); #1;
            tx_ready = !(got_q.size() == stall_idx && stalled < stall_len);
            if (!tx_ready) stalled++;
            @(negedge clock);
            if (i == 0) begin
                n_tests++;
                if (tx_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL read_first_valid_%02h: tx_valid got %b want 1", b, tx_valid);
                end
            end
            if (!tx_ready) begin
                exp_b = 8'(val >> (8 * stall_idx));
                n_tests++;
                if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
                    n_fail++;
                    $display("FAIL read_hold_%02h: tx_valid=%b tx_data=%h want 1 and %h", b, tx_valid, tx_data, exp_b);
                end
            end else if (tx_valid === 1'b1) begin
                got_q.push_back(tx_data);
            end
        end
        @(posedge clock); #1;
        tx_ready = 1'b1;
        @(negedge clock);
        n_tests++;
        if (cmd_ready !== 1'b1 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_done_%02h: cmd_ready=%b tx_valid=%b want 1 and 0", b, cmd_ready, tx_valid);
        end
        n_tests++;
        if (got_q.size() != nb) begin
            n_fail++;
            $display("FAIL read_count_%02h: got %0d bytes want %0d", b, got_q.size(), nb);
        end
        for (int k = 0; k < nb; k++) begin
            exp_b = 8'(val >> (8 * k));
            act_b = (k < got_q.size()) ? got_q[k] : 8'hxx;
            n_tests++;
            if (act_b !== exp_b) begin
                n_fail++;
                $display("FAIL read_byte%0d_%02h: got %h want %h", k, b, act_b, exp_b);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00;
        tx_ready = 1'b1; halt_req = 1'b0;
        #3;
        n_tests++;
        if (pipe_en !== 1'b0 || running !== 1'b0 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: pipe_en=%b running=%b tx_valid=%b want 0 0 0", pipe_en, running, tx_valid);
        end
        n_tests++;
        if (probe_sel !== 6'h00 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: probe_sel=%h tx_data=%h want 00 00", probe_sel, tx_data);
        end
        n_tests++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
        end
        cnt_model = 32'h0;
    endtask

    task automatic test_step();
        int t;
        clear_mon();
        send_cmd(8'h20, t);
        repeat (4) @(posedge clock);
        #1;
        n_tests++;
        if (pe_cnt != 1 || pe_first != t + 1 || tv_cnt != 0) begin
            n_fail++;
            $display("FAIL step: pe_cnt=%0d first=%0d tx_cycles=%0d want 1 %0d 0", pe_cnt, pe_first, tv_cnt, t + 1);
        end
        cnt_model += 32'd1;
    endtask

    task automatic test_run_halt_req(input int n);
        int t;
        clear_mon();
        tx_ready = 1'b1;
        send_cmd(8'h23, t);
        if (n > 1) begin
            repeat (n - 1) @(posedge clock);
            #1;
        end
        halt_req = 1'b1;
        @(negedge clock);
        n_tests++;
        if (running !== 1'b1 || pipe_en !== 1'b1) begin
            n_fail++;
            $display("FAIL run_active: running=%b pipe_en=%b want 1 1", running, pipe_en);
        end
        @(posedge clock); #1;
        halt_req = 1'b0;
        @(negedge clock);
        n_tests++;
        if (pipe_en !== 1'b0 || running !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'hB0) begin
            n_fail++;
            $display("FAIL notify: pipe_en=%b running=%b tx_valid=%b tx_data=%h want 0 0 1 b0", pipe_en, running, tx_valid, tx_data);
        end
        @(posedge clock); #1;
        @(negedge clock);
        n_tests++;
        if (tx_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL notify_done: tx_valid=%b cmd_ready=%b want 0 1", tx_valid, cmd_ready);
        end
        n_tests++;
        if (pe_cnt != n || pe_first != t + 1) begin
            n_fail++;
            $display("FAIL run_pe_count: got %0d from %0d want %0d from %0d", pe_cnt, pe_first, n, t + 1);
        end
        cnt_model += 32'(n);
    endtask

    task automatic test_cycles();
        logic [31:0] exp_v;
`ifdef DEBUG_CYCLE_COUNTER_EN
        exp_v = cnt_model;
`else
        exp_v = probe_mem[6'h25];
`endif
        do_read(8'hE5, exp_v, 4, 0);
    endtask

    task automatic test_run_discard();
        int t, t1, h;
        clear_mon();
        send_cmd(8'h23, t);
        repeat (2) @(posedge clock);
        send_cmd(8'h01, t1);
        send_cmd(8'h24, h);
        @(negedge clock);
        n_tests++;
        if (pipe_en !== 1'b0 || running !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL run_halt_stop: pipe_en=%b running=%b cmd_ready=%b want 0 0 1", pipe_en, running, cmd_ready);
        end
        repeat (4) @(posedge clock);
        #1;
        n_tests++;
        if (tv_cnt != 0 || pe_cnt != h - t || pe_last != h) begin
            n_fail++;
            $display("FAIL run_discard: tx_cycles=%0d pe_cnt=%0d last=%0d want 0 %0d %0d", tv_cnt, pe_cnt, pe_last, h - t, h);
        end
        cnt_model += 32'(h - t);
    endtask

    task automatic test_halt_collision();
        int t, h;
        clear_mon();
        tx_ready = 1'b1;
        send_cmd(8'h23, t);
        @(posedge clock); #1;
        cmd_data = 8'h24; cmd_valid = 1'b1; halt_req = 1'b1;
        @(negedge clock);
        h = cyc;
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_ready: got %b want 1", cmd_ready);
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0; halt_req = 1'b0;
        @(negedge clock);
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hB0 || pipe_en !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_notify: tx_valid=%b tx_data=%h pipe_en=%b want 1 b0 0", tx_valid, tx_data, pipe_en);
        end
        @(posedge clock); #1;
        @(negedge clock);
        n_tests++;
        if (tx_valid !== 1'b0 || cmd_ready !== 1'b1 || pe_cnt != h - t) begin
            n_fail++;
            $display("FAIL collide_done: tx_valid=%b cmd_ready=%b pe_cnt=%0d want 0 1 %0d", tx_valid, cmd_ready, pe_cnt, h - t);
        end
        cnt_model += 32'(h - t);
    endtask

    task automatic test_random();
        int r, sz;
        logic [5:0] code;
        for (int it = 0; it < 20; it++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                code = 6'($urandom_range(0, 63));
                if (code == 6'h20 || code == 6'h23 || code == 6'h24 || code == 6'h25)
                    code = code ^ 6'h10;
                sz = $urandom_range(0, 3);
                do_read({2'(sz), code}, probe_mem[code], $urandom_range(0, sz), $urandom_range(0, 3));
            end else if (r < 8) begin
                test_step();
            end else begin
                test_run_halt_req($urandom_range(1, 6));
            end
        end
    endtask

    task automatic test_reset_mid_send();
        int t;
        tx_ready = 1'b1;
        send_cmd(8'hC2, t);
        @(posedge clock); #1;
        @(negedge clock);
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== probe_mem[2][7:0]) begin
            n_fail++;
            $display("FAIL midsend_byte0: tx_valid=%b tx_data=%h want 1 %h", tx_valid, tx_data, probe_mem[2][7:0]);
        end
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || pipe_en !== 1'b0 || running !== 1'b0
            || probe_sel !== 6'h00 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midsend_reset: tx_valid=%b tx_data=%h pipe_en=%b running=%b probe_sel=%h cmd_ready=%b want all 0",
                     tx_valid, tx_data, pipe_en, running, probe_sel, cmd_ready);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        cnt_model = 32'h0;
        clear_mon();
        repeat (8) @(posedge clock);
        #1;
        n_tests++;
        if (tv_cnt != 0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midsend_after: tx_cycles=%0d cmd_ready=%b want 0 1", tv_cnt, cmd_ready);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) probe_mem[i] = $urandom;
        probe_mem[1]     = 32'h12345678;
        probe_mem[6'h25] = 32'h0;

        test_reset();
        test_step();
        do_read(8'hC1, 32'h12345678, 1, 3);
        do_read(8'h0A, probe_mem[6'h0A], 1, 0);
        test_run_halt_req(10);
        test_cycles();
        test_run_discard();
        test_halt_collision();
        test_random();
        test_cycles();
        test_reset_mid_send();
        test_cycles();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
